// File: rtl/threshold_writer.sv
// threshold_writer: final adaptive-threshold pass. Scans the frame in raster
// order, reads the original pixel and its local box mean at the same (col,row),
// and writes FG/BG to the result RAM with a fixed two-clock read latency.
module threshold_writer #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int OFFSET      = 8,
  parameter int FG          = 255,
  parameter int BG          = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   busy,
  output logic                   finished
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [WIDTH_BITS-1:0]  LAST_COL     = {WIDTH_BITS{1'b1}};
  localparam logic [WIDTH_BITS-1:0]  PRE_LAST_COL = WIDTH_BITS'((2 ** WIDTH_BITS) - 2);
  localparam logic [HEIGHT_BITS-1:0] LAST_ROW     = {HEIGHT_BITS{1'b1}};

  state_t                 state;
  logic                   drainCnt;

  logic [WIDTH_BITS-1:0]  col_p0;
  logic [HEIGHT_BITS-1:0] row_p0;
  logic                   vld_p0;

  logic [WIDTH_BITS-1:0]  col_p1;
  logic [HEIGHT_BITS-1:0] row_p1;
  logic                   vld_p1;

  logic [WIDTH_BITS-1:0]  col_p2;
  logic [HEIGHT_BITS-1:0] row_p2;
  logic [7:0]             data_p2;
  logic                   vld_p2;

  // Local threshold: mean minus OFFSET, clamped at zero instead of wrapping.
  function automatic logic [7:0] satThreshold(input logic [7:0] mean);
    logic signed [9:0] diff;
    diff = $signed({2'b00, mean}) - $signed(10'(OFFSET));
    if (diff < 0) return 8'd0;
    return diff[7:0];
  endfunction

  // Strictly-greater comparison: a pixel equal to the threshold is background.
  function automatic logic [7:0] binarise(input logic [7:0] pixel, input logic [7:0] thr);
    return (pixel > thr) ? 8'(FG) : 8'(BG);
  endfunction

  // Control FSM and raster read-address generator (stage p0).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      drainCnt <= 1'b0;
      col_p0   <= '0;
      row_p0   <= '0;
      vld_p0   <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (iStart) begin
            state    <= RUN;
            drainCnt <= 1'b0;
            col_p0   <= '0;
            row_p0   <= '0;
            vld_p0   <= 1'b1;
            busy     <= 1'b1;
            finished <= 1'b0;
          end
        end
        RUN: begin
          vld_p0 <= 1'b1;
          if (col_p0 == LAST_COL) begin
            col_p0 <= '0;
            row_p0 <= row_p0 + 1'b1;
          end else begin
            col_p0 <= col_p0 + 1'b1;
          end
          // Leave RUN on the edge that issues the final address.
          if (col_p0 == PRE_LAST_COL && row_p0 == LAST_ROW) state <= DRAIN;
        end
        DRAIN: begin
          vld_p0 <= 1'b0;
          if (drainCnt) begin
            state    <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else begin
            drainCnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pipeline: p1 aligns the address with returning memory data, p2 is the write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_p1  <= '0;
      row_p1  <= '0;
      vld_p1  <= 1'b0;
      col_p2  <= '0;
      row_p2  <= '0;
      data_p2 <= 8'd0;
      vld_p2  <= 1'b0;
    end else begin
      // stage p0 -> p1
      col_p1 <= col_p0;
      row_p1 <= row_p0;
      vld_p1 <= vld_p0;
      // stage p1 -> p2: write fields only move with a valid pixel
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        col_p2  <= col_p1;
        row_p2  <= row_p1;
        data_p2 <= binarise(iImageData, satThreshold(iMeanData));
      end
    end
  end

  assign oImageCol   = col_p0;
  assign oImageRow   = row_p0;
  assign oMeanCol    = col_p0;
  assign oMeanRow    = row_p0;
  assign oResultCol  = col_p2;
  assign oResultRow  = row_p2;
  assign oResultData = data_p2;
  assign oResultWren = vld_p2;

endmodule
